// File: rtl/wishbus_pkg.sv
// Shared types and constants for the wishbus copy initiator.
// State encoding, bus direction codes and default widths.
package wishbus_pkg;

  localparam int AW_DEF  = 32;
  localparam int DW_DEF  = 16;
  localparam int LW_DEF  = 10;
  localparam int TMO_DEF = 255;

  // bus_we polarity: high selects a read
  localparam logic BUS_RD = 1'b1;
  localparam logic BUS_WR = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE,
    ERR
  } state_t;

  function automatic logic is_req(input state_t s);
    return (s == RD_REQ) || (s == WR_REQ);
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == RD_WAIT) || (s == WR_WAIT);
  endfunction

endpackage

// File: rtl/wishbus_xact.sv
// Single bus-phase handshake: request acceptance, completion
// detection and a per-state timeout, shared by reads and writes.
module wishbus_xact
  import wishbus_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_req,
  input  logic in_wait,
  input  logic cyc,
  output logic acc,
  output logic fin,
  output logic tmo
);

  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);
  localparam logic [TW-1:0] TLIM = TW'(TMO);

  logic [TW-1:0] cnt;
  logic          active;

  assign active = in_req | in_wait;
  assign acc    = in_req & cyc;
  assign fin    = in_wait & ~cyc;
  assign tmo    = active & ~acc & ~fin & (cnt == TLIM);

  // every state change goes through acc/fin or an idle state,
  // so clearing there reloads the timer on each REQ/WAIT entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!active || acc || fin) begin
      cnt <= '0;
    end else if (cnt != TLIM) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wishbus_copy_initiator.sv
// Word-by-word memory copy initiator: reads src+2k, writes dst+2k,
// with per-phase timeout and word-boundary abort.
module wishbus_copy_initiator
  import wishbus_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int LW  = LW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_src_i,
  input  logic [AW-1:0] cmd_dst_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          bus_stb_o,
  output logic          bus_sel_no,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_dat_o,
  input  logic [DW-1:0] bus_dat_i,
  input  logic          bus_cyc_i
);

  localparam logic [AW-1:0] STEP = AW'(2);
  localparam logic [LW-1:0] ONE  = LW'(1);

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] src_nx;
  logic [AW-1:0] dst_nx;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_nx;
  logic [DW-1:0] hold;
  logic          accept;
  logic          acc;
  logic          fin;
  logic          tmo;

  assign accept    = cmd_valid_i & cmd_ready_o;
  assign bus_dat_o = hold;

  wishbus_xact #(
    .TMO (TMO)
  ) u_xact (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .in_req  (is_req(state)),
    .in_wait (is_wait(state)),
    .cyc     (bus_cyc_i),
    .acc     (acc),
    .fin     (fin),
    .tmo     (tmo)
  );

  // next state plus the address/count values it implies
  always_comb begin
    nxt    = state;
    src_nx = src;
    dst_nx = dst;
    cnt_nx = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          src_nx = cmd_src_i;
          dst_nx = cmd_dst_i;
          cnt_nx = cmd_len_i;
          if (cmd_len_i == '0) begin
            nxt = DONE;
          end else if (abort_i) begin
            nxt = ERR;
          end else begin
            nxt = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (acc) begin
          nxt = RD_WAIT;
        end else if (tmo) begin
          nxt = ERR;
        end
      end
      RD_WAIT: begin
        if (fin) begin
          nxt = WR_REQ;
        end else if (tmo) begin
          nxt = ERR;
        end
      end
      WR_REQ: begin
        if (acc) begin
          nxt = WR_WAIT;
        end else if (tmo) begin
          nxt = ERR;
        end
      end
      WR_WAIT: begin
        if (fin) begin
          src_nx = src + STEP;
          dst_nx = dst + STEP;
          cnt_nx = cnt - ONE;
          if (cnt == ONE) begin
            nxt = DONE;
          end else if (abort_i) begin
            nxt = ERR;
          end else begin
            nxt = RD_REQ;
          end
        end else if (tmo) begin
          nxt = ERR;
        end
      end
      DONE:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state, working registers and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      src         <= '0;
      dst         <= '0;
      cnt         <= '0;
      hold        <= '0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      bus_stb_o   <= 1'b0;
      bus_sel_no  <= 1'b1;
      bus_we_o    <= BUS_RD;
      bus_addr_o  <= '0;
    end else begin
      state       <= nxt;
      src         <= src_nx;
      dst         <= dst_nx;
      cnt         <= cnt_nx;
      cmd_ready_o <= (nxt == IDLE);
      busy_o      <= (nxt != IDLE);
      done_o      <= (nxt == DONE);
      err_o       <= (nxt == ERR);
      bus_stb_o   <= is_req(nxt);
      bus_sel_no  <= ~(is_req(nxt) | is_wait(nxt));
      if ((state == RD_WAIT) && fin) begin
        hold <= bus_dat_i;
      end
      if (nxt == RD_REQ) begin
        bus_addr_o <= src_nx;
        bus_we_o   <= BUS_RD;
      end else if (nxt == WR_REQ) begin
        bus_addr_o <= dst_nx;
        bus_we_o   <= BUS_WR;
      end else if ((nxt == DONE) || (nxt == ERR)) begin
        bus_we_o   <= BUS_RD;
      end
    end
  end

endmodule

// File: tb/tb_wishbus_copy_initiator.sv
// Directed bench for wishbus_copy_initiator with a small
// negedge-driven responder and hand-computed expectations.
module tb_wishbus_copy_initiator;

  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int LW  = 10;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic          bus_stb;
  logic          bus_sel_n;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_dat_o;
  logic [DW-1:0] bus_dat_i = '0;
  logic          bus_cyc = 1'b0;

  int n_run = 0;
  int n_fail = 0;
  int busy_cy = 2;
  bit rsp_en = 1'b1;
  int rcnt = 0;
  int done_n = 0;
  int err_n = 0;
  int stb_n = 0;

  logic [AW-1:0] rd_a[$];
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];

  always #5 clk = ~clk;

  wishbus_copy_initiator #(
    .AW  (AW),
    .DW  (DW),
    .LW  (LW),
    .TMO (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_src_i   (cmd_src),
    .cmd_dst_i   (cmd_dst),
    .cmd_len_i   (cmd_len),
    .abort_i     (abort),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .bus_stb_o   (bus_stb),
    .bus_sel_no  (bus_sel_n),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_dat_o   (bus_dat_o),
    .bus_dat_i   (bus_dat_i),
    .bus_cyc_i   (bus_cyc)
  );

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  // responder: takes a strobe, stays busy busy_cy cycles
  always @(negedge clk) begin
    if (!rsp_en) begin
      bus_cyc = 1'b0;
    end else if (!bus_cyc) begin
      if (bus_stb) begin
        bus_cyc = 1'b1;
        rcnt = busy_cy;
        if (bus_we) begin
          rd_a.push_back(bus_addr);
          bus_dat_i = mem(bus_addr);
        end else begin
          wr_a.push_back(bus_addr);
          wr_d.push_back(bus_dat_o);
        end
      end
    end else if (rcnt > 1) begin
      rcnt = rcnt - 1;
    end else begin
      bus_cyc = 1'b0;
    end
  end

  // pulse / strobe counters
  always @(negedge clk) begin
    if (done) done_n = done_n + 1;
    if (err) err_n = err_n + 1;
    if (bus_stb) stb_n = stb_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run = n_run + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd_at(input int i);
    return (i < rd_a.size()) ? 64'(rd_a[i]) : '1;
  endfunction

  function automatic logic [63:0] wa_at(input int i);
    return (i < wr_a.size()) ? 64'(wr_a[i]) : '1;
  endfunction

  function automatic logic [63:0] wd_at(input int i);
    return (i < wr_d.size()) ? 64'(wr_d[i]) : '1;
  endfunction

  task automatic clr();
    rd_a.delete();
    wr_a.delete();
    wr_d.delete();
    done_n = 0;
    err_n = 0;
    stb_n = 0;
  endtask

  task automatic send(input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input logic [LW-1:0] l);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) check("ready_wait", 0, 1);
    cmd_src = s;
    cmd_dst = d;
    cmd_len = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_src = 32'hDEAD_BEEF;
    cmd_dst = 32'hCAFE_F00D;
    cmd_len = '1;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_wait", 0, 1);
  endtask

  task automatic chk_reset(input string p);
    check({p, "_ready"}, 64'(cmd_ready), 1);
    check({p, "_busy"}, 64'(busy), 0);
    check({p, "_done"}, 64'(done), 0);
    check({p, "_err"}, 64'(err), 0);
    check({p, "_stb"}, 64'(bus_stb), 0);
    check({p, "_sel_n"}, 64'(bus_sel_n), 1);
    check({p, "_we"}, 64'(bus_we), 1);
    check({p, "_addr"}, 64'(bus_addr), 0);
    check({p, "_dat"}, 64'(bus_dat_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // len=3 copy, responder busy 2 cycles
    busy_cy = 2;
    clr();
    send(32'h100, 32'h200, 10'd3);
    wait_idle();
    check("c3_nrd", 64'(rd_a.size()), 3);
    check("c3_rd0", rd_at(0), 64'h100);
    check("c3_rd1", rd_at(1), 64'h102);
    check("c3_rd2", rd_at(2), 64'h104);
    check("c3_nwr", 64'(wr_a.size()), 3);
    check("c3_wa0", wa_at(0), 64'h200);
    check("c3_wa1", wa_at(1), 64'h202);
    check("c3_wa2", wa_at(2), 64'h204);
    check("c3_wd0", wd_at(0), 64'hA4C3);
    check("c3_wd1", wd_at(1), 64'hA4C1);
    check("c3_wd2", wd_at(2), 64'hA4C7);
    check("c3_done", 64'(done_n), 1);
    check("c3_err", 64'(err_n), 0);

    // len=0: done on the cycle after acceptance, no strobe
    clr();
    send(32'h10, 32'h20, 10'd0);
    check("l0_done", 64'(done), 1);
    check("l0_stb", 64'(bus_stb), 0);
    @(posedge clk);
    #1;
    check("l0_done_off", 64'(done), 0);
    check("l0_ready", 64'(cmd_ready), 1);
    check("l0_nstb", 64'(stb_n), 0);
    check("l0_err", 64'(err_n), 0);

    // silent responder: timeout
    rsp_en = 1'b0;
    clr();
    send(32'h800, 32'h900, 10'd1);
    k = 0;
    while (!err && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tmo_cycles", 64'(k), 64'(TMO + 1));
    check("tmo_stb", 64'(bus_stb), 0);
    check("tmo_sel_n", 64'(bus_sel_n), 1);
    @(posedge clk);
    #1;
    check("tmo_ready", 64'(cmd_ready), 1);
    check("tmo_err_off", 64'(err), 0);
    check("tmo_done", 64'(done_n), 0);
    rsp_en = 1'b1;
    wait_idle();

    // abort raised during word 1 of 4
    busy_cy = 1;
    clr();
    send(32'h300, 32'h400, 10'd4);
    k = 0;
    while (rd_a.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    abort = 1'b1;
    wait_idle();
    abort = 1'b0;
    check("ab_nrd", 64'(rd_a.size()), 2);
    check("ab_nwr", 64'(wr_a.size()), 2);
    check("ab_wa1", wa_at(1), 64'h402);
    check("ab_wd1", wd_at(1), 64'hA6C1);
    check("ab_err", 64'(err_n), 1);
    check("ab_done", 64'(done_n), 0);

    // source address wrap
    clr();
    send(32'hFFFF_FFFE, 32'h500, 10'd2);
    wait_idle();
    check("wr_rd0", rd_at(0), 64'hFFFF_FFFE);
    check("wr_rd1", rd_at(1), 64'h0);
    check("wr_wa1", wa_at(1), 64'h502);
    check("wr_wd0", wd_at(0), 64'h5A3D);
    check("wr_wd1", wd_at(1), 64'hA5C3);
    check("wr_done", 64'(done_n), 1);

    // asynchronous reset in WR_WAIT
    busy_cy = 3;
    clr();
    send(32'h600, 32'h700, 10'd2);
    k = 0;
    while (!(!bus_we && !bus_sel_n && !bus_stb) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ar_reach_wait", 64'(!bus_we && !bus_sel_n && !bus_stb), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("ar");
    k = 0;
    @(negedge clk);
    while (bus_cyc && k < 20) begin
      @(negedge clk);
      k++;
    end
    rst_n = 1'b1;
    busy_cy = 1;
    clr();
    send(32'hA00, 32'hB00, 10'd1);
    check("ar_accept", 64'(busy), 1);
    wait_idle();
    check("ar_wa0", wa_at(0), 64'hB00);
    check("ar_wd0", wd_at(0), 64'hAFC3);
    check("ar_done", 64'(done_n), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
